// File: rtl/vend_pkg.sv
// Shared definitions for the vending-machine coin scheduler.
// Holds the coin codes seen on the slot and vending-machine interfaces, the
// scheduler state encoding, the change codes reported by the machine, and a
// small helper that turns a slot index into a one-hot slot vector.
package vend_pkg;

  // Coin codes carried on req_coin and vm_in.
  localparam logic [1:0] COIN_NONE = 2'b00;
  localparam logic [1:0] COIN_5    = 2'b01;
  localparam logic [1:0] COIN_10   = 2'b10;
  localparam logic [1:0] COIN_BAD  = 2'b11;

  // Scheduler states.
  localparam logic [1:0] IDLE     = 2'b00;
  localparam logic [1:0] ISSUE    = 2'b01;
  localparam logic [1:0] WAIT     = 2'b10;
  localparam logic [1:0] DISPENSE = 2'b11;

  // Change codes reported by the vending machine on vm_change.
  localparam logic [1:0] CHG_NONE = 2'b00;
  localparam logic [1:0] CHG_5    = 2'b01;
  localparam logic [1:0] CHG_10   = 2'b10;

  // Slot index to one-hot slot vector (slot 0 -> 01, slot 1 -> 10).
  function automatic logic [1:0] slot_onehot(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/rr_arb2_lock.sv
// Two-requester round-robin arbiter with an owner lock.
// While the lock is active only the locked owner can be granted; otherwise a
// lone requester wins and a tie goes to the slot that was not granted last.
// The last_grant register only moves when the parent reports a transaction
// that actually started (update), so silently consumed or rejected coins do
// not disturb fairness.
// Ports:
//   clk, reset_n   clock and asynchronous active-low reset
//   enable         grants are only issued while high
//   req            per-slot request (valid) vector
//   lock_valid     an owner holds the machine
//   lock_owner     index of the owner slot
//   update         a transaction started for update_slot
//   update_slot    slot that started the transaction
//   grant          one-hot grant, combinational
module rr_arb2_lock
  import vend_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       enable,
  input  logic [1:0] req,
  input  logic       lock_valid,
  input  logic       lock_owner,
  input  logic       update,
  input  logic       update_slot,
  output logic [1:0] grant
);

  logic last_grant;

  // Out of reset last_grant points at slot 1 so slot 0 wins the first tie.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_grant <= 1'b1;
    end else if (update) begin
      last_grant <= update_slot;
    end
  end

  always_comb begin
    grant = 2'b00;
    if (enable) begin
      if (lock_valid) begin
        grant = req & slot_onehot(lock_owner);
      end else begin
        case (req)
          2'b01:   grant = 2'b01;
          2'b10:   grant = 2'b10;
          2'b11:   grant = last_grant ? 2'b01 : 2'b10;
          default: grant = 2'b00;
        endcase
      end
    end
  end

endmodule

// File: rtl/vend_coin_scheduler.sv
// Coin scheduler sitting in front of a vending machine with a single coin
// port. Two coin slots share that port: slots are arbitrated round-robin,
// and once a slot has put credit into the machine it owns the machine until
// its purchase vends. Each accepted coin is forwarded on vm_in for exactly
// one cycle, the machine's response is watched for RESP_LAT cycles, and a
// vend is followed by a DISP_CYCLES lockout during which no coin is taken.
// Ports:
//   clk, reset_n   clock and asynchronous active-low reset
//   req_valid      per-slot coin offered
//   req_coin       per-slot coin code ([1:0] slot 0, [3:2] slot 1)
//   req_ready      per-slot accept, combinational
//   vm_in          registered coin to the vending machine
//   vm_out         product vend strobe from the vending machine
//   vm_change      change code from the vending machine
//   vend_pulse     one-cycle one-hot slot that received the product
//   change_out     change captured at the last vend
//   reject_pulse   one-cycle slot whose illegal coin was swallowed
//   busy           scheduler not idle
//   vend_count     saturating vend counter
//   proto_err      sticky: vending machine vended outside the response window
module vend_coin_scheduler #(
  parameter int RESP_LAT    = 1,
  parameter int DISP_CYCLES = 4,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       req_valid,
  input  logic [3:0]       req_coin,
  output logic [1:0]       req_ready,
  output logic [1:0]       vm_in,
  input  logic             vm_out,
  input  logic [1:0]       vm_change,
  output logic [1:0]       vend_pulse,
  output logic [1:0]       change_out,
  output logic [1:0]       reject_pulse,
  output logic             busy,
  output logic [CNT_W-1:0] vend_count,
  output logic             proto_err
);

  import vend_pkg::*;

  // One timer serves both the response window and the dispense lockout.
  localparam int TMR_MAX = (RESP_LAT > DISP_CYCLES) ? RESP_LAT : DISP_CYCLES;
  localparam int TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;
  localparam logic [TMR_W-1:0] WAIT_LAST = TMR_W'(RESP_LAT - 1);
  localparam logic [TMR_W-1:0] DISP_LAST = TMR_W'(DISP_CYCLES - 1);

  logic [1:0]       state;
  logic             owner;
  logic             owner_valid;
  logic [TMR_W-1:0] timer;
  logic [1:0]       grant;
  logic             grant_slot;
  logic             handshake;
  logic [1:0]       coin_sel;
  logic             coin_ok;
  logic             arb_enable;

  // The reset term keeps req_ready low while reset is held, even though the
  // state register already reads IDLE.
  assign arb_enable = (state == IDLE) && reset_n;
  assign grant_slot = grant[1];
  assign handshake  = |(req_valid & grant);
  assign coin_sel   = grant_slot ? req_coin[3:2] : req_coin[1:0];
  assign coin_ok    = handshake && ((coin_sel == COIN_5) || (coin_sel == COIN_10));
  assign req_ready  = grant;
  assign busy       = (state != IDLE);

  rr_arb2_lock u_arb (
    .clk         (clk),
    .reset_n     (reset_n),
    .enable      (arb_enable),
    .req         (req_valid),
    .lock_valid  (owner_valid),
    .lock_owner  (owner),
    .update      (coin_ok),
    .update_slot (grant_slot),
    .grant       (grant)
  );

  // Main controller. vm_in, vend_pulse and reject_pulse default to zero each
  // cycle so they can only ever be one-cycle strobes. An accepted coin is
  // loaded straight into vm_in, which makes vm_in hold the coin exactly for
  // the ISSUE cycle. A window that closes without a vend returns to IDLE but
  // keeps the owner, because that owner's credit is still in the machine.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      owner        <= 1'b0;
      owner_valid  <= 1'b0;
      timer        <= '0;
      vm_in        <= COIN_NONE;
      vend_pulse   <= 2'b00;
      reject_pulse <= 2'b00;
      change_out   <= CHG_NONE;
      vend_count   <= '0;
      proto_err    <= 1'b0;
    end else begin
      vm_in        <= COIN_NONE;
      vend_pulse   <= 2'b00;
      reject_pulse <= 2'b00;

      if (vm_out && (state != WAIT)) begin
        proto_err <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (coin_ok) begin
            vm_in       <= coin_sel;
            owner       <= grant_slot;
            owner_valid <= 1'b1;
            state       <= ISSUE;
          end else if (handshake && (coin_sel == COIN_BAD)) begin
            reject_pulse <= slot_onehot(grant_slot);
          end
        end
        ISSUE: begin
          timer <= '0;
          state <= WAIT;
        end
        WAIT: begin
          if (vm_out) begin
            vend_pulse  <= slot_onehot(owner);
            change_out  <= vm_change;
            owner_valid <= 1'b0;
            timer       <= '0;
            state       <= DISPENSE;
            if (vend_count != {CNT_W{1'b1}}) begin
              vend_count <= vend_count + 1'b1;
            end
          end else if (timer == WAIT_LAST) begin
            state <= IDLE;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        DISPENSE: begin
          if (timer == DISP_LAST) begin
            state <= IDLE;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vend_coin_scheduler.sv
// Self-checking bench for vend_coin_scheduler.
// Two instances share all inputs: the default one (CNT_W=8) and a narrow one
// (CNT_W=2) whose counter must saturate at 3. A small vending machine model
// credits coins seen on vm_in, vends at 15 and answers one cycle after the
// coin, as a real machine with a one-cycle response would. Inputs change and
// outputs are sampled on the falling clock edge.
module tb_vend_coin_scheduler;

  localparam int DISP = 4;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [1:0] req_valid;
  logic [3:0] req_coin;
  logic       vm_out;
  logic [1:0] vm_change;

  logic [1:0] req_ready, vm_in, vend_pulse, change_out, reject_pulse;
  logic       busy, proto_err;
  logic [7:0] vend_count;

  logic [1:0] req_ready2, vm_in2, vend_pulse2, change_out2, reject_pulse2;
  logic       busy2, proto_err2;
  logic [1:0] vend_count2;

  int checks = 0;
  int errors = 0;

  // Vending machine model state.
  int         vm_credit;
  logic       vm_pend;
  logic [1:0] vm_pend_chg;
  logic       vm_force;

  always #5 clk = ~clk;

  vend_coin_scheduler dut (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_coin(req_coin),
    .req_ready(req_ready), .vm_in(vm_in), .vm_out(vm_out), .vm_change(vm_change),
    .vend_pulse(vend_pulse), .change_out(change_out), .reject_pulse(reject_pulse),
    .busy(busy), .vend_count(vend_count), .proto_err(proto_err)
  );

  vend_coin_scheduler #(.CNT_W(2)) dut2 (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_coin(req_coin),
    .req_ready(req_ready2), .vm_in(vm_in2), .vm_out(vm_out), .vm_change(vm_change),
    .vend_pulse(vend_pulse2), .change_out(change_out2), .reject_pulse(reject_pulse2),
    .busy(busy2), .vend_count(vend_count2), .proto_err(proto_err2)
  );

  function automatic logic [1:0] oneHot(input int s);
    return (s != 0) ? 2'b10 : 2'b01;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Compares the same output of both instances against one expectation.
  task automatic checkPair(input string name, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] exp);
    checkOutput({name, " (w8)"}, a, exp);
    checkOutput({name, " (w2)"}, b, exp);
  endtask

  task automatic applyStimulus(input logic [1:0] v, input logic [3:0] c);
    req_valid = v;
    req_coin  = c;
    #1;
  endtask

  // Vending machine: vm_out for the coming cycle reflects the coin seen in
  // the cycle just ended. Change is noise except at a vend.
  task automatic vmTick();
    if (!reset_n) begin
      vm_credit   = 0;
      vm_pend     = 1'b0;
      vm_pend_chg = 2'b00;
      vm_out      = vm_force;
      vm_change   = 2'b00;
      return;
    end
    vm_out    = vm_pend | vm_force;
    vm_change = vm_pend ? vm_pend_chg : 2'($urandom_range(0, 3));
    vm_pend   = 1'b0;
    if (vm_in != 2'b00) begin
      vm_credit += (vm_in == 2'b01) ? 5 : (vm_in == 2'b10) ? 10 : 0;
      if (vm_credit >= 15) begin
        vm_pend     = 1'b1;
        vm_pend_chg = (vm_credit - 15 == 5) ? 2'b01 : 2'b00;
        vm_credit   = 0;
      end
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
    vmTick();
  endtask

  task automatic doReset();
    reset_n  = 1'b0;
    vm_force = 1'b0;
    applyStimulus(2'b00, 4'b0000);
    cycle();
    cycle();
    reset_n = 1'b1;
  endtask

  // Two coins of 10 from one slot starting in IDLE; k is the purchase number.
  task automatic buyTwoTens(input int s, input int k);
    logic [1:0] v;
    logic [3:0] c;
    v = oneHot(s);
    c = (s != 0) ? 4'b1000 : 4'b0010;
    applyStimulus(v, c); cycle(); applyStimulus(2'b00, 4'b0000); cycle(); cycle();
    applyStimulus(v, c); cycle(); applyStimulus(2'b00, 4'b0000); cycle(); cycle();
    checkPair($sformatf("buy%0d vend_pulse", k), vend_pulse, vend_pulse2, v);
    checkOutput($sformatf("buy%0d count w8", k), vend_count, k);
    checkOutput($sformatf("buy%0d count w2", k), vend_count2, (k > 3) ? 3 : k);
    repeat (DISP) cycle();
  endtask

  typedef struct {
    logic [1:0] valid;
    logic [3:0] coin;
    logic [1:0] exp_ready;
    logic [1:0] exp_reject;
  } vec_t;

  vec_t vecs[8];

  // Reference model state for the randomized phase.
  int         idle_from, issue_cyc, vend_cyc, rej_cyc;
  int         m_owner, m_last, m_credit, m_count, g;
  bit         m_owner_valid;
  logic [1:0] issue_coin, rej_oh, vend_oh, vend_chg, exp_change, exp_r, rv, coin;
  logic [3:0] rc;

  initial begin
    // After reset last_grant = 1, so slot 0 wins ties; rejected and empty
    // coins must not move it.
    vecs[0] = '{2'b00, 4'b0000, 2'b00, 2'b00};
    vecs[1] = '{2'b01, 4'b0000, 2'b01, 2'b00};
    vecs[2] = '{2'b10, 4'b0000, 2'b10, 2'b00};
    vecs[3] = '{2'b11, 4'b0000, 2'b01, 2'b00};
    vecs[4] = '{2'b10, 4'b1100, 2'b10, 2'b10};
    vecs[5] = '{2'b01, 4'b0011, 2'b01, 2'b01};
    vecs[6] = '{2'b11, 4'b1111, 2'b01, 2'b01};
    vecs[7] = '{2'b11, 4'b0000, 2'b01, 2'b00};

    reset_n = 1'b1; vm_force = 1'b0; vm_out = 1'b0; vm_change = 2'b00;
    vm_credit = 0; vm_pend = 1'b0; vm_pend_chg = 2'b00;
    req_valid = 2'b00; req_coin = 4'b0000;

    // Reset values, with both slots requesting while reset is held.
    #2 reset_n = 1'b0;
    applyStimulus(2'b11, 4'b0000);
    checkPair("rst ready", req_ready, req_ready2, 0);
    checkPair("rst vm_in", vm_in, vm_in2, 0);
    checkPair("rst vend_pulse", vend_pulse, vend_pulse2, 0);
    checkPair("rst reject", reject_pulse, reject_pulse2, 0);
    checkPair("rst change", change_out, change_out2, 0);
    checkPair("rst busy", busy, busy2, 0);
    checkPair("rst count", vend_count, vend_count2, 0);
    checkPair("rst proto_err", proto_err, proto_err2, 0);
    @(negedge clk);
    doReset();

    // Arbitration and reject table.
    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i].valid, vecs[i].coin);
      checkPair($sformatf("vec%0d ready", i), req_ready, req_ready2, vecs[i].exp_ready);
      cycle();
      applyStimulus(2'b00, 4'b0000);
      checkPair($sformatf("vec%0d reject", i), reject_pulse, reject_pulse2, vecs[i].exp_reject);
      checkPair($sformatf("vec%0d busy", i), busy, busy2, 0);
      checkPair($sformatf("vec%0d vm_in", i), vm_in, vm_in2, 0);
    end
    cycle();

    // Slot 0 pays 5 then 10; lock holds slot 1 off; lockout then slot 1.
    $display("[TB] sequence: slot0 5+10 purchase");
    applyStimulus(2'b01, 4'b0001);
    checkPair("A ready c0", req_ready, req_ready2, 2'b01);
    cycle(); applyStimulus(2'b00, 4'b0000);
    checkPair("A vm_in c1", vm_in, vm_in2, 2'b01);
    checkPair("A busy c1", busy, busy2, 1);
    cycle();
    checkPair("A vm_in c2", vm_in, vm_in2, 2'b00);
    cycle();
    checkPair("A busy c3", busy, busy2, 0);
    checkPair("A no vend c3", vend_pulse, vend_pulse2, 0);
    applyStimulus(2'b11, 4'b0110);
    checkPair("A lock ready c3", req_ready, req_ready2, 2'b01);
    cycle(); applyStimulus(2'b00, 4'b0000);
    checkPair("A vm_in c4", vm_in, vm_in2, 2'b10);
    cycle(); cycle();
    checkPair("A vend_pulse c6", vend_pulse, vend_pulse2, 2'b01);
    checkPair("A change c6", change_out, change_out2, 2'b00);
    checkPair("A count c6", vend_count, vend_count2, 1);
    applyStimulus(2'b11, 4'b0000);
    checkPair("A ready c6", req_ready, req_ready2, 0);
    for (int j = 7; j < 10; j++) begin
      cycle();
      checkPair($sformatf("A ready c%0d", j), req_ready, req_ready2, 0);
      checkPair($sformatf("A vend_pulse c%0d", j), vend_pulse, vend_pulse2, 0);
    end
    cycle();
    checkPair("A ready c10", req_ready, req_ready2, 2'b10);
    checkPair("A busy c10", busy, busy2, 0);
    cycle(); applyStimulus(2'b00, 4'b0000);
    checkPair("A coin00 vm_in", vm_in, vm_in2, 0);
    checkPair("A coin00 busy", busy, busy2, 0);

    // Reset during WAIT discards the coin and the owner.
    $display("[TB] sequence: reset mid-transaction");
    applyStimulus(2'b01, 4'b0001);
    checkPair("E ready c0", req_ready, req_ready2, 2'b01);
    cycle(); applyStimulus(2'b11, 4'b0000);
    checkPair("E vm_in c1", vm_in, vm_in2, 2'b01);
    cycle();
    reset_n = 1'b0;
    #1;
    checkPair("E rst ready", req_ready, req_ready2, 0);
    checkPair("E rst busy", busy, busy2, 0);
    checkPair("E rst count", vend_count, vend_count2, 0);
    checkPair("E rst vm_in", vm_in, vm_in2, 0);
    checkPair("E rst change", change_out, change_out2, 0);
    cycle(); cycle();
    reset_n = 1'b1;
    applyStimulus(2'b10, 4'b0100);
    checkPair("E post ready", req_ready, req_ready2, 2'b10);
    cycle(); applyStimulus(2'b00, 4'b0000);
    checkPair("E post vm_in", vm_in, vm_in2, 2'b01);
    cycle(); cycle();
    checkPair("E post no vend", vend_pulse, vend_pulse2, 0);
    checkPair("E post count", vend_count, vend_count2, 0);

    // Both slots offer 10 right after reset.
    $display("[TB] sequence: contention after reset");
    doReset();
    applyStimulus(2'b11, 4'b1010);
    checkPair("B ready c0", req_ready, req_ready2, 2'b01);
    cycle();
    checkPair("B vm_in c1", vm_in, vm_in2, 2'b10);
    checkPair("B ready c1", req_ready, req_ready2, 0);
    cycle();
    checkPair("B ready c2", req_ready, req_ready2, 0);
    cycle();
    checkPair("B ready c3", req_ready, req_ready2, 2'b01);
    cycle(); applyStimulus(2'b10, 4'b1000);
    checkPair("B vm_in c4", vm_in, vm_in2, 2'b10);
    checkPair("B ready c4", req_ready, req_ready2, 0);
    cycle(); cycle();
    checkPair("B vend_pulse c6", vend_pulse, vend_pulse2, 2'b01);
    checkPair("B change c6", change_out, change_out2, 2'b01);
    checkPair("B ready c6", req_ready, req_ready2, 0);
    repeat (3) cycle();
    checkPair("B ready c9", req_ready, req_ready2, 0);
    checkPair("B change held", change_out, change_out2, 2'b01);
    cycle();
    checkPair("B ready c10", req_ready, req_ready2, 2'b10);
    cycle(); applyStimulus(2'b00, 4'b0000);
    checkPair("B vm_in c11", vm_in, vm_in2, 2'b10);
    cycle(); cycle();

    // Five purchases: narrow counter saturates at 3.
    $display("[TB] sequence: counter saturation");
    doReset();
    for (int k = 1; k <= 5; k++) buyTwoTens(k % 2, k);

    // vm_out in IDLE flags a protocol error that sticks until reset.
    $display("[TB] sequence: protocol error");
    checkPair("G proto before", proto_err, proto_err2, 0);
    vm_force = 1'b1;
    cycle();
    vm_force = 1'b0;
    cycle();
    checkPair("G proto set", proto_err, proto_err2, 1);
    repeat (3) cycle();
    checkPair("G proto sticky", proto_err, proto_err2, 1);
    checkPair("G busy", busy, busy2, 0);
    checkOutput("G count kept", vend_count, 5);
    doReset();
    checkPair("G proto cleared", proto_err, proto_err2, 0);

    // Randomized traffic against a timestamp-based reference model.
    $display("[TB] sequence: random traffic");
    doReset();
    idle_from = 0; issue_cyc = -1; vend_cyc = -1; rej_cyc = -1;
    m_owner = 0; m_last = 1; m_credit = 0; m_count = 0; m_owner_valid = 0;
    issue_coin = 0; rej_oh = 0; vend_oh = 0; vend_chg = 0; exp_change = 0;
    for (int n = 0; n < 500; n++) begin
      if (n == vend_cyc) begin
        m_count++;
        exp_change = vend_chg;
      end
      checkPair("rnd vm_in", vm_in, vm_in2, (n == issue_cyc) ? issue_coin : 2'b00);
      checkPair("rnd vend_pulse", vend_pulse, vend_pulse2, (n == vend_cyc) ? vend_oh : 2'b00);
      checkPair("rnd reject", reject_pulse, reject_pulse2, (n == rej_cyc) ? rej_oh : 2'b00);
      checkPair("rnd busy", busy, busy2, (n < idle_from) ? 1 : 0);
      checkPair("rnd change", change_out, change_out2, exp_change);
      checkOutput("rnd count w8", vend_count, (m_count > 255) ? 255 : m_count);
      checkOutput("rnd count w2", vend_count2, (m_count > 3) ? 3 : m_count);
      checkPair("rnd proto_err", proto_err, proto_err2, 0);

      rv = 2'($urandom_range(0, 3));
      rc = 4'($urandom_range(0, 15));
      applyStimulus(rv, rc);
      exp_r = 2'b00;
      if (n >= idle_from) begin
        if (m_owner_valid) exp_r = rv[m_owner] ? oneHot(m_owner) : 2'b00;
        else if (rv == 2'b01) exp_r = 2'b01;
        else if (rv == 2'b10) exp_r = 2'b10;
        else if (rv == 2'b11) exp_r = (m_last == 0) ? 2'b10 : 2'b01;
      end
      checkPair("rnd ready", req_ready, req_ready2, exp_r);

      if (exp_r != 2'b00) begin
        g    = exp_r[1] ? 1 : 0;
        coin = (g != 0) ? rc[3:2] : rc[1:0];
        if (coin == 2'b11) begin
          rej_cyc = n + 1;
          rej_oh  = exp_r;
        end else if (coin != 2'b00) begin
          m_last     = g;
          issue_cyc  = n + 1;
          issue_coin = coin;
          m_credit  += (coin == 2'b01) ? 5 : 10;
          if (m_credit >= 15) begin
            vend_cyc      = n + 3;
            vend_oh       = exp_r;
            vend_chg      = (m_credit == 20) ? 2'b01 : 2'b00;
            m_credit      = 0;
            m_owner_valid = 0;
            idle_from     = n + 3 + DISP;
          end else begin
            m_owner_valid = 1;
            m_owner       = g;
            idle_from     = n + 3;
          end
        end
      end
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
